// File: rtl/data_sram_bridge_pkg.sv
// Shared encodings for the data SRAM bridge: FSM states and bus size codes.
package data_sram_bridge_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      StIdle = S_IDLE,
      StAddr = S_ADDR,
      StData = S_DATA,
      StHold = S_HOLD
   } state_e;

endpackage

// File: rtl/data_sram_bridge_if.sv
// SRAM-like split-handshake data bus (req/addr_ok/data_ok).
interface data_sram_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic                  req;
   logic                  wr;
   logic [1:0]            size;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/data_sram_bridge_data_size_dec.sv
// Byte-lane select to bus transfer size: full mask, aligned half, single lane; else word.
module data_size_dec
   import data_sram_bridge_pkg::*;
#(
   parameter int unsigned SEL_W = 4
) (
   input  logic [SEL_W-1:0] sel,
   output logic [1:0]       size
);

   int unsigned onesCnt;
   logic        isHalf;

   always_comb begin
      onesCnt = 0;
      isHalf  = 1'b0;
      for (int i = 0; i < int'(SEL_W); i++) begin
         onesCnt = onesCnt + 32'(sel[i]);
      end
      for (int k = 0; k < int'(SEL_W / 2); k++) begin
         if (sel == (SEL_W'(2'b11) << (2 * k))) begin
            isHalf = 1'b1;
         end
      end
   end

   always_comb begin
      size = SZ_WORD;
      if (onesCnt == 1) begin
         size = SZ_BYTE;
      end else if (isHalf) begin
         size = SZ_HALF;
      end
   end

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle data port onto a split-handshake SRAM-like bus,
// stalling the pipeline while a transaction is in flight.
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                mem_en,
   input  logic                mem_wen,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_sel,
   output logic [DATA_W-1:0]   mem_rdata,
   input  logic                pipe_stall,
   output logic                mem_stall,
   data_sram_bridge_if.master  bus
);

   state_e                stateQ;
   logic                  reqWrQ;
   logic [1:0]            reqSizeQ;
   logic [ADDR_W-1:0]     reqAddrQ;
   logic [DATA_W/8-1:0]   reqWstrbQ;
   logic [DATA_W-1:0]     reqWdataQ;
   logic [DATA_W-1:0]     rdataBufQ;

   logic [1:0]            selSize;
   logic [DATA_W/8-1:0]   selStrb;

   logic                  reqRaw;
   logic                  wrRaw;
   logic                  stallRaw;
   logic [DATA_W-1:0]     rdataRaw;

   data_size_dec #(
      .SEL_W (DATA_W / 8)
   ) u_size_dec (
      .sel  (mem_sel),
      .size (selSize)
   );

   assign selStrb = mem_wen ? mem_sel : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stateQ    <= StIdle;
         reqWrQ    <= 1'b0;
         reqSizeQ  <= 2'd0;
         reqAddrQ  <= '0;
         reqWstrbQ <= '0;
         reqWdataQ <= '0;
         rdataBufQ <= '0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (mem_en) begin
                  reqWrQ    <= mem_wen;
                  reqSizeQ  <= selSize;
                  reqAddrQ  <= mem_addr;
                  reqWstrbQ <= selStrb;
                  reqWdataQ <= mem_wdata;
                  stateQ    <= bus.addr_ok ? StData : StAddr;
               end
            end
            StAddr: begin
               if (bus.addr_ok) begin
                  stateQ <= StData;
               end
            end
            StData: begin
               if (bus.data_ok) begin
                  if (!reqWrQ) begin
                     rdataBufQ <= bus.rdata;
                  end
                  stateQ <= pipe_stall ? StHold : StIdle;
               end
            end
            StHold: begin
               if (!pipe_stall) begin
                  stateQ <= StIdle;
               end
            end
         endcase
      end
   end

   // IDLE issues straight from the core inputs so a request costs no extra cycle;
   // later states replay the captured request.
   always_comb begin
      reqRaw    = 1'b0;
      wrRaw     = reqWrQ;
      stallRaw  = 1'b0;
      rdataRaw  = rdataBufQ;
      bus.size  = reqSizeQ;
      bus.addr  = reqAddrQ;
      bus.wstrb = reqWstrbQ;
      bus.wdata = reqWdataQ;
      unique case (stateQ)
         StIdle: begin
            reqRaw    = mem_en;
            stallRaw  = mem_en;
            wrRaw     = mem_en & mem_wen;
            bus.size  = selSize;
            bus.addr  = mem_addr;
            bus.wstrb = selStrb;
            bus.wdata = mem_wdata;
         end
         StAddr: begin
            reqRaw   = 1'b1;
            stallRaw = 1'b1;
         end
         StData: begin
            stallRaw = ~bus.data_ok;
            if (bus.data_ok) begin
               rdataRaw = bus.rdata;
            end
         end
         StHold: begin
            stallRaw = 1'b0;
         end
      endcase
   end

   // Gated by resetn so the combinational IDLE path is quiet during reset too.
   assign bus.req   = resetn & reqRaw;
   assign bus.wr    = resetn & wrRaw;
   assign mem_stall = resetn & stallRaw;
   assign mem_rdata = resetn ? rdataRaw : '0;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench: vector table of bus transactions plus hand-written reset sequences.
module tb_data_sram_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_en;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_rdata;
   logic        pipe_stall;
   logic        mem_stall;

   data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_sram_bridge #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .mem_en     (mem_en),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_sel    (mem_sel),
      .mem_rdata  (mem_rdata),
      .pipe_stall (pipe_stall),
      .mem_stall  (mem_stall),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          addrDly;
      int          dataDly;
      int          holdCyc;
      logic        corrupt;
      logic        gap;
      logic [31:0] rdata;
      logic [1:0]  expSize;
      logic [3:0]  expStrb;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } busExp_t;

   busExp_t     sbQ[$];
   logic [31:0] bufModel;
   int          total = 0;
   int          bad = 0;
   vec_t        vecs[11];

   function automatic vec_t mk(logic wen, logic [31:0] addr, logic [31:0] wdata, logic [3:0] sel,
                               int addrDly, int dataDly, int holdCyc, logic corrupt, logic gap,
                               logic [31:0] rdata, logic [1:0] expSize, logic [3:0] expStrb);
      vec_t v;
      v.wen = wen; v.addr = addr; v.wdata = wdata; v.sel = sel;
      v.addrDly = addrDly; v.dataDly = dataDly; v.holdCyc = holdCyc;
      v.corrupt = corrupt; v.gap = gap; v.rdata = rdata;
      v.expSize = expSize; v.expStrb = expStrb;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Request-phase check against the scoreboard head; pops on acceptance.
   task automatic checkReq();
      busExp_t e;
      check("req_asserted", bus.req, 1'b1);
      check("req_stall", mem_stall, 1'b1);
      if (sbQ.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sbQ[0];
         check("bus_wr", bus.wr, e.wr);
         check("bus_size", bus.size, e.size);
         check("bus_addr", bus.addr, e.addr);
         check("bus_wstrb", bus.wstrb, e.wstrb);
         check("bus_wdata", bus.wdata, e.wdata);
         if (bus.addr_ok) void'(sbQ.pop_front());
      end
   endtask

   task automatic runTxn(input vec_t v);
      busExp_t e;
      e.wr = v.wen; e.size = v.expSize; e.addr = v.addr; e.wstrb = v.expStrb; e.wdata = v.wdata;
      sbQ.push_back(e);
      nextCycle();
      mem_en = 1'b1; mem_wen = v.wen; mem_addr = v.addr; mem_wdata = v.wdata; mem_sel = v.sel;
      pipe_stall = 1'b0; bus.data_ok = 1'b0; bus.addr_ok = (v.addrDly == 0);
      #3;
      checkReq();
      for (int i = 1; i <= v.addrDly; i++) begin
         nextCycle();
         if (v.corrupt) begin
            mem_addr = 32'hFFFF_0000; mem_wdata = ~v.wdata; mem_wen = ~v.wen; mem_sel = 4'b0001;
         end
         bus.addr_ok = (i == v.addrDly);
         #3;
         checkReq();
      end
      for (int i = 1; i <= v.dataDly; i++) begin
         nextCycle();
         bus.addr_ok = 1'b0;
         bus.data_ok = (i == v.dataDly);
         bus.rdata = bus.data_ok ? v.rdata : 32'hBAD0_BAD0;
         pipe_stall = bus.data_ok && (v.holdCyc > 0);
         #3;
         check("data_req_low", bus.req, 1'b0);
         if (!bus.data_ok) begin
            check("data_wait_stall", mem_stall, 1'b1);
         end else begin
            check("data_ok_stall", mem_stall, 1'b0);
            check("data_ok_bypass", mem_rdata, v.rdata);
            if (!v.wen) bufModel = v.rdata;
         end
      end
      for (int i = 0; i < v.holdCyc; i++) begin
         nextCycle();
         bus.data_ok = 1'b1;
         bus.rdata = 32'hCAFE_0000;
         pipe_stall = (i < v.holdCyc - 1);
         #3;
         check("hold_stall", mem_stall, 1'b0);
         check("hold_req", bus.req, 1'b0);
         check("hold_rdata", mem_rdata, bufModel);
      end
      if (v.gap) begin
         nextCycle();
         mem_en = 1'b0; pipe_stall = 1'b0; bus.data_ok = 1'b0; bus.addr_ok = 1'b0;
         #3;
         check("idle_req", bus.req, 1'b0);
         check("idle_stall", mem_stall, 1'b0);
         check("idle_rdata", mem_rdata, bufModel);
      end
   endtask

   initial begin
      vecs[0]  = mk(1'b0, 32'h1000, 32'h0, 4'hF, 0, 2, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd2, 4'h0);
      vecs[1]  = mk(1'b1, 32'h1002, 32'h00AB_0000, 4'h4, 0, 1, 1, 1'b0, 1'b1, 32'h5555_5555,
                    2'd0, 4'h4);
      vecs[2]  = mk(1'b0, 32'h1000, 32'h1111_2222, 4'hF, 3, 1, 0, 1'b1, 1'b1, 32'h0BAD_F00D,
                    2'd2, 4'h0);
      vecs[3]  = mk(1'b0, 32'h3000, 32'h0, 4'h3, 0, 1, 2, 1'b0, 1'b1, 32'h1234_5678, 2'd1, 4'h0);
      vecs[4]  = mk(1'b1, 32'h3002, 32'hBEEF_0000, 4'hC, 1, 1, 0, 1'b0, 1'b1, 32'h0, 2'd1, 4'hC);
      vecs[5]  = mk(1'b1, 32'h3003, 32'h7700_0000, 4'h8, 0, 3, 1, 1'b0, 1'b1, 32'h0, 2'd0, 4'h8);
      vecs[6]  = mk(1'b0, 32'h3004, 32'h0, 4'h5, 0, 1, 0, 1'b0, 1'b1, 32'hA5A5_5A5A, 2'd2, 4'h0);
      vecs[7]  = mk(1'b0, 32'h3005, 32'h0, 4'h2, 2, 2, 0, 1'b0, 1'b1, 32'h0000_3300, 2'd0, 4'h0);
      vecs[8]  = mk(1'b0, 32'h2000, 32'h0, 4'hF, 0, 1, 0, 1'b0, 1'b0, 32'h2000_0001, 2'd2, 4'h0);
      vecs[9]  = mk(1'b0, 32'h2004, 32'h0, 4'hF, 0, 1, 0, 1'b0, 1'b1, 32'h2004_0002, 2'd2, 4'h0);
      vecs[10] = mk(1'b1, 32'h5000, 32'h0102_0304, 4'h0, 0, 1, 0, 1'b0, 1'b1, 32'h0, 2'd2, 4'h0);

      bufModel = 32'h0;
      resetn = 1'b0; mem_en = 1'b1; mem_wen = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'h0;
      mem_sel = 4'hF; pipe_stall = 1'b0;
      bus.addr_ok = 1'b1; bus.data_ok = 1'b1; bus.rdata = 32'hFFFF_FFFF;
      #12;
      check("rst_req", bus.req, 1'b0);
      check("rst_wr", bus.wr, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_rdata", mem_rdata, 32'h0);
      nextCycle();
      mem_en = 1'b0; bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
      resetn = 1'b1;
      #3;
      check("post_rst_req", bus.req, 1'b0);
      check("post_rst_stall", mem_stall, 1'b0);

      for (int n = 0; n < 11; n++) begin
         runTxn(vecs[n]);
      end

      // Reset asserted while the load sits in DATA.
      nextCycle();
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4000; mem_sel = 4'hF;
      bus.addr_ok = 1'b1; bus.data_ok = 1'b0;
      #3;
      check("mid_req", bus.req, 1'b1);
      nextCycle();
      bus.addr_ok = 1'b0;
      #2;
      check("mid_data_stall", mem_stall, 1'b1);
      resetn = 1'b0;
      #1;
      check("async_req", bus.req, 1'b0);
      check("async_stall", mem_stall, 1'b0);
      check("async_rdata", mem_rdata, 32'h0);
      bufModel = 32'h0;
      nextCycle();
      resetn = 1'b1; mem_en = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h7777_7777;
      #3;
      check("late_ok_stall", mem_stall, 1'b0);
      check("late_ok_rdata", mem_rdata, 32'h0);
      check("late_ok_req", bus.req, 1'b0);
      nextCycle();
      bus.data_ok = 1'b0;
      #3;
      check("late_ok_buf", mem_rdata, 32'h0);

      runTxn(mk(1'b0, 32'h6000, 32'h0, 4'hF, 0, 1, 1, 1'b0, 1'b1, 32'h6666_0006, 2'd2, 4'h0));

      check("scoreboard_drained", 64'(sbQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the CPU core's memory stage. Converts the core's single-cycle data SRAM port (memen/memwrite/aluout/writedata/sel/readdata) into an SRAM-like split handshake bus (req/addr_ok/data_ok).
- Stalls the pipeline while a transaction is outstanding.
- Holds returned load data until the pipeline is free to advance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte strobes.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_en  in  1  M-stage access valid (core memenM)
- mem_wen  in  1  store when 1 (core memwriteM)
- mem_addr  in  ADDR_W  byte address (core aluoutM)
- mem_wdata  in  DATA_W  store data, already lane-aligned
- mem_sel  in  DATA_W/8  byte-lane select (core selM)
- mem_rdata  out  DATA_W  load data back to core (readdataM)
- pipe_stall  in  1  M stage held by another source
- mem_stall  out  1  bridge requests pipeline stall
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  ADDR_W  bus address
- data_wstrb  out  DATA_W/8  bus byte strobes
- data_wdata  out  DATA_W  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write complete
- data_rdata  in  DATA_W  bus read data

Behaviour:
- FSM states: IDLE, ADDR, DATA, HOLD. Reset state is IDLE.
- Reset (resetn=0, asynchronous): state=IDLE, request registers=0, rdata_buf=0. Outputs forced to 0: data_req, data_wr, mem_stall, mem_rdata.
- Size decode from mem_sel:
  - 1111 -> 2
  - 0011 or 1100 -> 1
  - one-hot -> 0
  - any other pattern -> 2
- data_wstrb = mem_sel for writes, 0 for reads.
- IDLE with mem_en=1:
  - data_req=1 combinationally; data_* driven directly from mem_* inputs; mem_stall=1.
  - The same edge captures addr/wdata/wen/size/wstrb into request registers.
  - addr_ok=1 -> DATA; addr_ok=0 -> ADDR.
- IDLE with mem_en=0: data_req=0, mem_stall=0.
- ADDR:
  - data_req=1, fields driven from request registers (input changes are ignored); mem_stall=1.
  - addr_ok=1 -> DATA.
- DATA:
  - data_req=0.
  - data_ok=0: mem_stall=1.
  - data_ok=1: mem_stall=0 that cycle; mem_rdata=data_rdata (bypass); rdata_buf<=data_rdata for reads, unchanged for writes.
  - Next state: pipe_stall=0 -> IDLE; pipe_stall=1 -> HOLD.
- HOLD:
  - mem_stall=0, mem_rdata=rdata_buf, data_req=0.
  - No new request even though mem_en is still 1.
  - pipe_stall=0 -> IDLE.
- Latency: best case, req to data_ok is 1 cycle. Stall duration equals the bus latency; there is no extra bridge bubble.
- At most one outstanding transaction. data_ok is ignored in IDLE, ADDR and HOLD.
- addr_ok and data_ok in the same cycle as the request: accepted; the FSM stays in DATA for one cycle minimum. The bus must not assert data_ok before the cycle following addr_ok.
- Back-to-back: after DATA->IDLE, a new mem_en in the next cycle issues immediately.
- Reset mid-transaction: the transaction is abandoned; the bus shares resetn.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams S_IDLE, S_ADDR, S_DATA, S_HOLD).
  - Size codes SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One combinational sub-module, data_size_dec: mem_sel -> data_size.
- FSM, request registers and rdata_buf stay in the top.

Test Plan:
- Word load at 0x1000, sel=1111, addr_ok in the request cycle, data_ok 2 cycles later with rdata=0xDEADBEEF -> data_size=2, data_wstrb=0, mem_stall=1 for 2 cycles then 0. mem_rdata=0xDEADBEEF in the data_ok cycle. Back in IDLE the next cycle.
- Byte store at 0x1002, sel=0100, wdata=0x00AB0000 -> data_wr=1, data_size=0, data_wstrb=0100, data_wdata=0x00AB0000. rdata_buf unchanged.
- addr_ok held low 3 cycles while mem_addr is driven to 0xFFFF0000 after the first cycle -> data_addr stays 0x1000 throughout ADDR; data_req=1 for 4 cycles.
- data_ok with rdata=0x12345678 while pipe_stall=1 for 2 more cycles -> state HOLD, mem_stall=0, mem_rdata=0x12345678, data_req=0 in HOLD. IDLE after pipe_stall falls.
- resetn pulsed low during DATA -> data_req, mem_stall and mem_rdata are 0 immediately (asynchronous). State is IDLE after release. A data_ok arriving after reset is ignored.
- Two consecutive loads (0x2000, 0x2004), each with 1-cycle bus latency -> second req issued the cycle after the first data_ok. No lost or duplicated request.
